bank: RTL and testbench

Single reference-pixel storage bank for the DMT motion-estimation datapath. It holds 128 rows of eight 8-bit reference pixels (64 bits per row). Rows are loaded from the reference fetch path and read back to the search array through a registered output. A system holds several such banks; `Bank_sel` enables one of them.

---
 rtl/bank.sv | 56 +++++
 tb/tb_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bank.sv
// Reference-pixel storage bank: 128 rows of eight 8-bit pixels, loaded from the
// reference fetch path and read back to the search array through a registered output.
module bank #(
  parameter int PIXEL   = 8,
  parameter int ROW_PIX = 8,
  parameter int DEPTH   = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       beg_en,
  input  logic [ROW_PIX*PIXEL-1:0]   ref_in,
  input  logic                       Bank_sel,
  input  logic [$clog2(DEPTH)-1:0]   address,
  input  logic                       rd_en,
  output logic [ROW_PIX*PIXEL-1:0]   ref_ou
);

  localparam int W = ROW_PIX * PIXEL;

  // Requests are single-cycle level qualifiers sampled on each rising edge; there is
  // no valid/ready handshake. A read wins over a write, so the two never coexist.
  logic         wr_fire;
  logic         rd_fire;
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] ref_ou_d;
  logic [W-1:0] ref_ou_q;

  always_comb begin
    wr_fire  = Bank_sel & beg_en & ~rd_en;
    rd_fire  = Bank_sel & rd_en;
    mem_d    = mem_q;
    ref_ou_d = ref_ou_q;
    if (wr_fire) begin
      mem_d[address] = ref_in;
    end
    // Output only changes on a read; written data is never forwarded to ref_ou.
    if (rd_fire) begin
      ref_ou_d = mem_q[address];
    end
  end

  // Storage is a flop array so every row can be cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      ref_ou_q <= '0;
    end else begin
      mem_q    <= mem_d;
      ref_ou_q <= ref_ou_d;
    end
  end

  assign ref_ou = ref_ou_q;

endmodule

// File: tb/tb_bank.sv
// Directed bench for bank: reset clearing, write hold, read latency and priority,
// deselect behaviour, a full address sweep and an asynchronous mid-sweep reset.
module tb_bank;

  logic        clk;
  logic        rst_n;
  logic        beg_en;
  logic [63:0] ref_in;
  logic        bank_sel;
  logic [6:0]  address;
  logic        rd_en;
  logic [63:0] ref_ou;

  int checks;
  int errors;

  bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .beg_en   (beg_en),
    .ref_in   (ref_in),
    .Bank_sel (bank_sel),
    .address  (address),
    .rd_en    (rd_en),
    .ref_ou   (ref_ou)
  );

  // Clock: rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep8(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {8{b}};
  endfunction

  task automatic do_write(input logic [6:0] a, input logic [63:0] d);
    bank_sel = 1'b1; beg_en = 1'b1; rd_en = 1'b0; address = a; ref_in = d;
    step();
    beg_en = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a);
    bank_sel = 1'b1; beg_en = 1'b0; rd_en = 1'b1; address = a;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    beg_en   = 1'b0;
    ref_in   = '0;
    bank_sel = 1'b0;
    address  = '0;
    rd_en    = 1'b0;

    // Reset for 10 ns, released away from a rising edge.
    #1;
    check("reset_during", ref_ou, 64'h0);
    #9;
    rst_n = 1'b1;
    #1;
    check("reset_after", ref_ou, 64'h0);
    do_read(7'd0);   check("reset_rd_0",   ref_ou, 64'h0);
    do_read(7'd64);  check("reset_rd_64",  ref_ou, 64'h0);
    do_read(7'd127); check("reset_rd_127", ref_ou, 64'h0);

    // Write-only: the output must never show write data.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) begin
        bank_sel = 1'b1; beg_en = 1'b1; rd_en = 1'b0; address = 7'd0;
        ref_in = (p == 0) ? 64'h0F0F0F0F0F0F0F0F :
                 (p == 1) ? 64'h5555555555555555 : 64'h3333333333333333;
        step();
        check("wr_hold", ref_ou, 64'h0);
      end
    end
    beg_en = 1'b0;
    do_read(7'd0); check("wr_hold_rd0", ref_ou, 64'h3333333333333333);

    // Read latency and hold.
    do_write(7'd5, 64'h0123456789ABCDEF);
    do_read(7'd5); check("rd_lat", ref_ou, 64'h0123456789ABCDEF);
    step();        check("rd_hold1", ref_ou, 64'h0123456789ABCDEF);
    address = 7'd0;
    step();        check("rd_hold2", ref_ou, 64'h0123456789ABCDEF);

    // Read priority: simultaneous read and write leaves memory untouched.
    do_write(7'd9, 64'h1111111111111111);
    bank_sel = 1'b1; rd_en = 1'b1; beg_en = 1'b1; address = 7'd9;
    ref_in = 64'hFFFFFFFFFFFFFFFF;
    step();
    rd_en = 1'b0; beg_en = 1'b0;
    check("prio_rd", ref_ou, 64'h1111111111111111);
    do_read(7'd0); check("prio_other", ref_ou, 64'h3333333333333333);
    do_read(7'd9); check("prio_mem", ref_ou, 64'h1111111111111111);

    // Deselect: no writes, no reads, output holds.
    do_write(7'd3, 64'hA5A5A5A5A5A5A5A5);
    do_read(7'd3); check("desel_pre", ref_ou, 64'hA5A5A5A5A5A5A5A5);
    do_read(7'd9); check("desel_pre9", ref_ou, 64'h1111111111111111);
    bank_sel = 1'b0; beg_en = 1'b1; rd_en = 1'b0; address = 7'd3;
    ref_in = 64'hDEADBEEFDEADBEEF;
    step(); step();
    check("desel_wr_hold", ref_ou, 64'h1111111111111111);
    beg_en = 1'b0; rd_en = 1'b1;
    step(); step();
    check("desel_rd_hold", ref_ou, 64'h1111111111111111);
    rd_en = 1'b0;
    do_read(7'd3); check("desel_mem", ref_ou, 64'hA5A5A5A5A5A5A5A5);

    // Full sweep: back-to-back writes then back-to-back reads.
    bank_sel = 1'b1; beg_en = 1'b1; rd_en = 1'b0;
    for (int i = 0; i < 128; i++) begin
      address = i[6:0];
      ref_in  = rep8(i);
      step();
    end
    beg_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      address = i[6:0];
      step();
      check("sweep_rd", ref_ou, rep8(i));
    end

    // Reset asserted mid-sweep, between clock edges.
    for (int i = 0; i < 61; i++) begin
      address = i[6:0];
      step();
      check("sweep2_rd", ref_ou, rep8(i));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", ref_ou, 64'h0);
    #10;
    rst_n = 1'b1;
    step();
    rd_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      address = i[6:0];
      step();
      check("post_rst_rd", ref_ou, 64'h0);
    end
    rd_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
